// File: rtl/cpu_mem_responder.sv
// Data-memory responder for the CPU load/store path with configurable read latency.
// Optional MMIO display register: define MEM_RESP_MMIO_EN.
module cpu_mem_responder #(
    parameter int DataWidth   = 16,
    parameter int NumRegs     = 65536,
    parameter int ReadLatency = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic                 reqWrite,
    input  logic [15:0]          reqAddr,
    input  logic [DataWidth-1:0] reqWData,
    output logic                 respValid,
    input  logic                 respReady,
    output logic                 respWrite,
    output logic [DataWidth-1:0] respData
`ifdef MEM_RESP_MMIO_EN
    ,
    output logic [DataWidth-1:0] displayOut
`endif
);

    localparam int AddrW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, nextState;

    logic [DataWidth-1:0] mem [NumRegs];
    logic [AddrW-1:0]     reqIdx;
    logic [AddrW-1:0]     addrQ;
    logic [3:0]           cnt;
    logic                 accept;
    logic                 mmioHit;
    logic [DataWidth-1:0] accRd;
    logic [DataWidth-1:0] waitRd;

    assign reqIdx = reqAddr[AddrW-1:0];
    assign accept = reqValid && reqReady;

`ifdef MEM_RESP_MMIO_EN
    logic mmioQ;

    assign mmioHit = (reqAddr == 16'hFFFF);
    assign accRd   = mmioHit ? displayOut : mem[reqIdx];
    assign waitRd  = mmioQ ? displayOut : mem[addrQ];

    // Display register and the load-side flag that selects it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            displayOut <= '0;
            mmioQ      <= 1'b0;
        end else if (accept) begin
            mmioQ <= mmioHit;
            if (reqWrite && mmioHit)
                displayOut <= reqWData;
        end
    end
`else
    assign mmioHit = 1'b0;
    assign accRd   = mem[reqIdx];
    assign waitRd  = mem[addrQ];
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state and handshake outputs
    always_comb begin
        nextState = state;
        reqReady  = 1'b0;
        respValid = 1'b0;
        unique case (state)
            IDLE: begin
                reqReady = 1'b1;
                if (reqValid) begin
                    if (reqWrite || ReadLatency == 1)
                        nextState = RESP;
                    else
                        nextState = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1)
                    nextState = RESP;
            end
            RESP: begin
                respValid = 1'b1;
                if (respReady)
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Storage write port; contents are not reset
    always_ff @(posedge clk) begin
        if (accept && reqWrite && !mmioHit && !rst)
            mem[reqIdx] <= reqWData;
    end

    // Response payload, latched address and latency counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            respWrite <= 1'b0;
            respData  <= '0;
            addrQ     <= '0;
            cnt       <= 4'd0;
        end else if (accept) begin
            respWrite <= reqWrite;
            addrQ     <= reqIdx;
            if (reqWrite) begin
                respData <= reqWData;
            end else begin
                cnt <= 4'(ReadLatency - 1);
                if (ReadLatency == 1)
                    respData <= accRd;
            end
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1)
                respData <= waitRd;
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: latency 1 / 64K words and
// latency 3 / 256 words instances against a queue-free associative memory model.
module tb_cpu_mem_responder;

    logic        clk;
    logic        rst       [2];
    logic        reqValid  [2];
    logic        reqReady  [2];
    logic        reqWrite  [2];
    logic [15:0] reqAddr   [2];
    logic [15:0] reqWData  [2];
    logic        respValid [2];
    logic        respReady [2];
    logic        respWrite [2];
    logic [15:0] respData  [2];
`ifdef MEM_RESP_MMIO_EN
    logic [15:0] dispA, dispB;
    logic [15:0] dispMdl [2];
`endif

    int cmp;
    int bad;
    logic [15:0] mdl [int];

    cpu_mem_responder #(.DataWidth(16), .NumRegs(65536), .ReadLatency(1)) dutA (
        .clk(clk), .rst(rst[0]),
        .reqValid(reqValid[0]), .reqReady(reqReady[0]), .reqWrite(reqWrite[0]),
        .reqAddr(reqAddr[0]), .reqWData(reqWData[0]),
        .respValid(respValid[0]), .respReady(respReady[0]),
        .respWrite(respWrite[0]), .respData(respData[0])
`ifdef MEM_RESP_MMIO_EN
        , .displayOut(dispA)
`endif
    );

    cpu_mem_responder #(.DataWidth(16), .NumRegs(256), .ReadLatency(3)) dutB (
        .clk(clk), .rst(rst[1]),
        .reqValid(reqValid[1]), .reqReady(reqReady[1]), .reqWrite(reqWrite[1]),
        .reqAddr(reqAddr[1]), .reqWData(reqWData[1]),
        .respValid(respValid[1]), .respReady(respReady[1]),
        .respWrite(respWrite[1]), .respData(respData[1])
`ifdef MEM_RESP_MMIO_EN
        , .displayOut(dispB)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int latOf(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int nregsOf(input int d);
        return (d == 0) ? 65536 : 256;
    endfunction

    function automatic int key(input int d, input logic [15:0] a);
        return d * 65536 + (int'(a) % nregsOf(d));
    endfunction

    task automatic txn(input int d, input logic wr, input logic [15:0] a,
                       input logic [15:0] wd, input int hold, input string tag);
        logic [15:0] exp;
        logic        isMmio;
        int          cyc;
        int          want;
        isMmio = 1'b0;
`ifdef MEM_RESP_MMIO_EN
        isMmio = (a == 16'hFFFF);
`endif
        exp = 16'h0;
        if (wr) begin
            exp = wd;
            if (!isMmio)
                mdl[key(d, a)] = wd;
`ifdef MEM_RESP_MMIO_EN
            else
                dispMdl[d] = wd;
`endif
        end else begin
            if (!isMmio)
                exp = mdl[key(d, a)];
`ifdef MEM_RESP_MMIO_EN
            else
                exp = dispMdl[d];
`endif
        end
        want = wr ? 1 : latOf(d);
        @(negedge clk);
        cmp++;
        if (reqReady[d] !== 1'b1) begin
            bad++;
            $display("FAIL %s reqReady idle: got %b want 1", tag, reqReady[d]);
        end
        reqValid[d]  = 1'b1;
        reqWrite[d]  = wr;
        reqAddr[d]   = a;
        reqWData[d]  = wd;
        respReady[d] = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        reqValid[d] = 1'b0;
        reqAddr[d]  = 16'($urandom);
        reqWData[d] = 16'($urandom);
        cyc = 1;
        while (respValid[d] !== 1'b1 && cyc < 40) begin
            cmp++;
            if (reqReady[d] !== 1'b0) begin
                bad++;
                $display("FAIL %s reqReady wait: got %b want 0", tag, reqReady[d]);
            end
            @(negedge clk);
            cyc++;
        end
        cmp++;
        if (cyc !== want) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", tag, cyc, want);
        end
        cmp++;
        if (respWrite[d] !== wr) begin
            bad++;
            $display("FAIL %s respWrite: got %b want %b", tag, respWrite[d], wr);
        end
        cmp++;
        if (respData[d] !== exp) begin
            bad++;
            $display("FAIL %s respData: got %h want %h", tag, respData[d], exp);
        end
        for (int i = 0; i < hold; i++) begin
            reqValid[d] = 1'b1;
            reqWrite[d] = 1'b1;
            reqAddr[d]  = 16'h0077;
            reqWData[d] = 16'hDEAD;
            @(negedge clk);
            cmp++;
            if (respValid[d] !== 1'b1 || respData[d] !== exp ||
                respWrite[d] !== wr || reqReady[d] !== 1'b0) begin
                bad++;
                $display("FAIL %s hold%0d: valid %b data %h write %b ready %b want 1 %h %b 0",
                         tag, i, respValid[d], respData[d], respWrite[d], reqReady[d], exp, wr);
            end
        end
        reqValid[d]  = 1'b0;
        respReady[d] = 1'b1;
        @(negedge clk);
        respReady[d] = 1'b0;
        cmp++;
        if (respValid[d] !== 1'b0 || reqReady[d] !== 1'b1) begin
            bad++;
            $display("FAIL %s take: valid %b ready %b want 0 1", tag, respValid[d], reqReady[d]);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            reqValid[d] = 1'b0;
            reqWrite[d] = 1'b0;
            reqAddr[d] = 16'h0;
            reqWData[d] = 16'h0;
            respReady[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            cmp++;
            if (reqReady[d] !== 1'b1 || respValid[d] !== 1'b0 ||
                respWrite[d] !== 1'b0 || respData[d] !== 16'h0) begin
                bad++;
                $display("FAIL reset dut%0d: ready %b valid %b write %b data %h want 1 0 0 0000",
                         d, reqReady[d], respValid[d], respWrite[d], respData[d]);
            end
        end
`ifdef MEM_RESP_MMIO_EN
        dispMdl[0] = 16'h0;
        dispMdl[1] = 16'h0;
        cmp++;
        if (dispA !== 16'h0 || dispB !== 16'h0) begin
            bad++;
            $display("FAIL reset displayOut: got %h %h want 0000", dispA, dispB);
        end
`endif
    endtask

    task automatic test_store_load();
        txn(0, 1'b0 | 1'b1, 16'h0077, 16'h7777, 0, "preloadA");
        txn(1, 1'b1, 16'h0077, 16'h5151, 0, "preloadB");
        txn(0, 1'b1, 16'h0010, 16'hBEEF, 0, "storeA");
        txn(0, 1'b0, 16'h0010, 16'h0000, 0, "loadA");
    endtask

    task automatic test_latency();
        txn(1, 1'b1, 16'h0005, 16'h1234, 0, "preload5");
        txn(1, 1'b0, 16'h0005, 16'h0000, 0, "lat3load");
    endtask

    task automatic test_backpressure();
        txn(0, 1'b0, 16'h0010, 16'h0000, 4, "bpLoadA");
        txn(0, 1'b1, 16'h0020, 16'h4242, 4, "bpStoreA");
        txn(1, 1'b0, 16'h0005, 16'h0000, 4, "bpLoadB");
        txn(0, 1'b0, 16'h0077, 16'h0000, 0, "intruderA");
        txn(1, 1'b0, 16'h0077, 16'h0000, 0, "intruderB");
    endtask

    task automatic test_wrap();
        txn(1, 1'b1, 16'h0103, 16'hA5A5, 0, "wrapStB");
        txn(1, 1'b0, 16'h0003, 16'h0000, 0, "wrapLdB");
        txn(0, 1'b1, 16'h0003, 16'h1111, 0, "nowrapSt3");
        txn(0, 1'b1, 16'h0103, 16'hA5A5, 0, "nowrapSt103");
        txn(0, 1'b0, 16'h0003, 16'h0000, 0, "nowrapLd3");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        reqValid[1] = 1'b1;
        reqWrite[1] = 1'b0;
        reqAddr[1]  = 16'h0005;
        respReady[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid[1] = 1'b0;
        #1 rst[1] = 1'b1;
        #1;
        cmp++;
        if (respValid[1] !== 1'b0 || reqReady[1] !== 1'b1) begin
            bad++;
            $display("FAIL midReset in rst: valid %b ready %b want 0 1", respValid[1], reqReady[1]);
        end
        @(negedge clk);
        rst[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmp++;
            if (respValid[1] !== 1'b0 || reqReady[1] !== 1'b1) begin
                bad++;
                $display("FAIL midReset after%0d: valid %b ready %b want 0 1",
                         i, respValid[1], reqReady[1]);
            end
        end
        respReady[1] = 1'b0;
        txn(1, 1'b0, 16'h0005, 16'h0000, 0, "afterReset");
    endtask

`ifdef MEM_RESP_MMIO_EN
    task automatic test_mmio();
        txn(0, 1'b1, 16'hFFFF, 16'h00FF, 0, "mmioStA");
        cmp++;
        if (dispA !== 16'h00FF) begin
            bad++;
            $display("FAIL mmio displayOut A: got %h want 00ff", dispA);
        end
        txn(0, 1'b0, 16'hFFFF, 16'h0000, 0, "mmioLdA");
        txn(1, 1'b1, 16'hFFFF, 16'h0C0C, 2, "mmioStB");
        cmp++;
        if (dispB !== 16'h0C0C) begin
            bad++;
            $display("FAIL mmio displayOut B: got %h want 0c0c", dispB);
        end
        txn(1, 1'b0, 16'hFFFF, 16'h0000, 0, "mmioLdB");
        txn(1, 1'b0, 16'h0077, 16'h0000, 0, "mmioNoWrB");
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int          d;
            logic [15:0] a;
            logic        wr;
            d  = n % 2;
            a  = 16'($urandom_range(0, 40) + 256 * $urandom_range(0, 255));
            wr = 1'($urandom_range(0, 1));
            if (!mdl.exists(key(d, a)))
                wr = 1'b1;
            txn(d, wr, a, 16'($urandom), $urandom_range(0, 3), "rand");
        end
    endtask

    initial begin
        cmp = 0;
        bad = 0;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        test_reset();
        test_store_load();
        test_latency();
        test_backpressure();
        test_wrap();
        test_reset_mid();
`ifdef MEM_RESP_MMIO_EN
        test_mmio();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
